// File: rtl/deco_seq_pkg.sv
// Shared encodings for the decode-stage issue sequencer: FSM states, unit selection,
// opcode constants and trap causes.
package deco_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_FETCH    = 3'd1;
  localparam state_t ST_DECODE   = 3'd2;
  localparam state_t ST_DISPATCH = 3'd3;
  localparam state_t ST_EXEC     = 3'd4;
  localparam state_t ST_RETIRE   = 3'd5;
  localparam state_t ST_TRAP     = 3'd6;

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_MULT = 2'd1,
    UNIT_IRQ  = 2'd2,
    UNIT_MEM  = 2'd3
  } unit_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IRQ   = 7'b0011000;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  localparam logic [11:0] CODIF_INVALID = 12'h000;

  // mul_bit is instruction bit 25 (funct7[0]), which splits MUL from plain R-type.
  function automatic unit_t select_unit(input logic [6:0] opcode, input logic mul_bit);
    unit_t unit;
    unit = UNIT_ALU;
    if (opcode == OP_RTYPE && mul_bit) begin
      unit = UNIT_MULT;
    end else if (opcode == OP_IRQ) begin
      unit = UNIT_IRQ;
    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
      unit = UNIT_MEM;
    end
    return unit;
  endfunction

endpackage

// File: rtl/deco_seq_watchdog.sv
// EXEC-phase watchdog: counts enabled cycles since the last clear and flags the last
// cycle a unit is allowed before a timeout trap.
module deco_seq_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/deco_sequencer.sv
// Decode-stage issue sequencer: accepts one instruction, strobes the decoder, runs it on
// a single execution unit and either retires it or raises a trap.
module deco_sequencer
  import deco_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        inst_valid,
  input  logic [31:0] inst_in,
  output logic        inst_ready,
  output logic [31:0] inst_reg,
  output logic        dec_enable,
  input  logic [11:0] codif,
  output logic        alu_en,
  output logic        mul_en,
  output logic        irq_en,
  output logic        mem_en,
  input  logic        alu_done,
  input  logic        mul_done,
  input  logic        irq_done,
  input  logic        mem_done,
  output logic        pc_advance,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  input  logic        trap_ack
);

  state_t      state_q, state_d;
  logic [31:0] inst_reg_q, inst_reg_d;
  unit_t       unit_q, unit_d;
  logic [1:0]  cause_q, cause_d;
  logic        unit_done;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  // Only the selected unit's done is visible to the FSM.
  always_comb begin
    unit_done = 1'b0;
    case (unit_q)
      UNIT_ALU:  unit_done = alu_done;
      UNIT_MULT: unit_done = mul_done;
      UNIT_IRQ:  unit_done = irq_done;
      UNIT_MEM:  unit_done = mem_done;
      default:   unit_done = 1'b0;
    endcase
  end

  assign wd_clear  = (state_q == ST_DISPATCH);
  assign wd_enable = (state_q == ST_EXEC);

  deco_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .rstn   (rstn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    inst_reg_d = inst_reg_q;
    unit_d     = unit_q;
    cause_d    = cause_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (inst_valid) begin
          inst_reg_d = inst_in;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (codif == CODIF_INVALID) begin
          cause_d = TRAP_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          unit_d  = select_unit(inst_reg_q[6:0], inst_reg_q[25]);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // A done arriving on the last granted cycle still retires.
        if (unit_done) begin
          state_d = ST_RETIRE;
        end else if (wd_expired) begin
          cause_d = TRAP_TIMEOUT;
          state_d = ST_TRAP;
        end
      end
      ST_RETIRE: begin
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        if (trap_ack) begin
          cause_d = TRAP_NONE;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      inst_reg_q <= 32'd0;
      unit_q     <= UNIT_ALU;
      cause_q    <= TRAP_NONE;
    end else begin
      state_q    <= state_d;
      inst_reg_q <= inst_reg_d;
      unit_q     <= unit_d;
      cause_q    <= cause_d;
    end
  end

  assign inst_ready = (state_q == ST_FETCH);
  assign inst_reg   = inst_reg_q;
  assign dec_enable = (state_q == ST_DECODE);
  assign alu_en     = (state_q == ST_EXEC) && (unit_q == UNIT_ALU);
  assign mul_en     = (state_q == ST_EXEC) && (unit_q == UNIT_MULT);
  assign irq_en     = (state_q == ST_EXEC) && (unit_q == UNIT_IRQ);
  assign mem_en     = (state_q == ST_EXEC) && (unit_q == UNIT_MEM);
  assign pc_advance = (state_q == ST_RETIRE);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign busy       = (state_q == ST_DECODE) || (state_q == ST_DISPATCH) ||
                      (state_q == ST_EXEC) || (state_q == ST_RETIRE) || (state_q == ST_TRAP);

endmodule

// File: tb/tb_deco_sequencer.sv
// Randomised scoreboard bench for deco_sequencer: two lanes (TIMEOUT 255 and 4) share the
// clock; each has its own stimulus process and output monitor.
module tb_deco_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit lane_done [2];

  typedef struct {
    int          ev;     // cycle in which pc_advance or trap first shows
    int          unit;   // 0 ALU, 1 MULT, 2 IRQ, 3 MEM, 4 none
    int          n;      // number of cycles the unit enable is high
    bit          trap;
    logic [1:0]  cause;
    logic [31:0] inst;
  } exp_t;

  task automatic check(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL lane%0d %s: got 0x%0h, required 0x%0h (cycle %0d)", lane, name, act, exp,
               cyc);
    end
  endtask

  function automatic int unit_of(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op == 7'b0110011 && inst[25]) return 1;
    if (op == 7'b0011000) return 2;
    if (op == 7'b0000011 || op == 7'b0100011) return 3;
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int TO     = (g == 0) ? 255 : 4;
    localparam int N_INST = (g == 0) ? 250 : 80;
    localparam int BUDGET = (g == 0) ? 30000 : 8000;

    logic        rstn;
    logic        inst_valid;
    logic [31:0] inst_in;
    logic        inst_ready;
    logic [31:0] inst_reg;
    logic        dec_enable;
    logic [11:0] codif;
    logic [3:0]  en;
    logic [3:0]  done;
    logic        pc_advance;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        trap_ack;

    deco_sequencer #(
      .TIMEOUT(TO)
    ) dut (
      .clock     (clock),
      .rstn      (rstn),
      .inst_valid(inst_valid),
      .inst_in   (inst_in),
      .inst_ready(inst_ready),
      .inst_reg  (inst_reg),
      .dec_enable(dec_enable),
      .codif     (codif),
      .alu_en    (en[0]),
      .mul_en    (en[1]),
      .irq_en    (en[2]),
      .mem_en    (en[3]),
      .alu_done  (done[0]),
      .mul_done  (done[1]),
      .irq_done  (done[2]),
      .mem_done  (done[3]),
      .pc_advance(pc_advance),
      .busy      (busy),
      .trap      (trap),
      .trap_cause(trap_cause),
      .trap_ack  (trap_ack)
    );

    exp_t sb[$];

    // Monitor-owned model state.
    int         pops        = 0;
    int         traps_seen  = 0;
    int         retire_free = 0;
    logic [1:0] held_cause  = 2'b00;
    int         en_cnt [4];
    bit         trap_q      = 1'b0;
    exp_t       mon_e;

    always @(negedge clock) begin
      if (!rstn) begin
        for (int u = 0; u < 4; u++) en_cnt[u] = 0;
        trap_q = 1'b0;
      end else begin
        for (int u = 0; u < 4; u++) if (en[u]) en_cnt[u]++;
        if (pc_advance || (trap && !trap_q)) begin
          if (sb.size() == 0) begin
            check(g, "unexpected_event", {30'd0, pc_advance, trap}, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            pops++;
            check(g, "event_cycle", cyc, mon_e.ev);
            check(g, "event_kind", {30'd0, pc_advance, trap}, mon_e.trap ? 32'd1 : 32'd2);
            for (int u = 0; u < 4; u++)
              check(g, "unit_en_cycles", en_cnt[u], (u == mon_e.unit) ? mon_e.n : 0);
            check(g, "inst_reg", inst_reg, mon_e.inst);
            if (mon_e.trap) begin
              held_cause = mon_e.cause;
              traps_seen++;
            end else begin
              retire_free = mon_e.ev + 1;
            end
          end
          for (int u = 0; u < 4; u++) en_cnt[u] = 0;
        end
        check(g, "trap_cause", trap_cause, trap ? held_cause : 2'b00);
        trap_q = trap;
      end
    end

    // Stimulus, done responder and trap acknowledger.
    initial begin
      int          accepted;
      int          traps_acked;
      int          drv_free;
      int          exec_cnt;
      int          cur_unit;
      int          cur_delay;
      int          quota;
      int          c;
      int          w;
      int          seen;
      int          dly;
      bit          exp_ready;
      logic [31:0] pick_inst;
      logic [11:0] pick_codif;
      exp_t        e;

      accepted    = 0;
      traps_acked = 0;
      exec_cnt    = 0;
      cur_unit    = 4;
      cur_delay   = 0;
      rstn        = 1'b0;
      inst_valid  = 1'b1;
      inst_in     = 32'hAA330D93;
      codif       = 12'h001;
      done        = 4'b1111;
      trap_ack    = 1'b1;
      repeat (3) @(negedge clock);
      check(g, "reset_outputs",
            {21'd0, inst_ready, dec_enable, en, pc_advance, busy, trap, trap_cause}, 32'd0);
      check(g, "reset_inst_reg", inst_reg, 32'd0);
      rstn = 1'b1;
      #1;
      check(g, "ready_before_first_edge", inst_ready, 1'b0);
      drv_free = cyc + 1;

      for (int phase = 0; phase < 2; phase++) begin
        quota = (phase == 0) ? N_INST : accepted + 3;
        c = 0;
        while (c < BUDGET) begin
          @(negedge clock);
          #1;
          c++;
          exp_ready = (pops == accepted) && (traps_seen == traps_acked) &&
                      (cyc >= retire_free) && (cyc >= drv_free);
          check(g, "inst_ready", inst_ready, exp_ready);
          check(g, "busy", busy, !exp_ready);

          if (en != 4'b0000) exec_cnt++;
          else exec_cnt = 0;
          for (int u = 0; u < 4; u++)
            done[u] = (u == cur_unit) ? (en[u] && exec_cnt == cur_delay)
                                      : 1'($urandom_range(0, 1));

          trap_ack = ($urandom_range(0, 2) == 0);
          if (trap_ack && traps_seen != traps_acked) begin
            traps_acked = traps_seen;
            drv_free    = cyc + 1;
          end

          if (accepted < quota && $urandom_range(0, 3) != 0) begin
            pick_codif = 12'($urandom_range(1, 4095));
            case ($urandom_range(0, 7))
              0: pick_inst = 32'hAA330D93;
              1: pick_inst = 32'h02330CB3;
              2: pick_inst = 32'h00330CB3;
              3: pick_inst = 32'hAA332D83;
              4: pick_inst = 32'h00A12023;
              5: begin
                pick_inst      = $urandom;
                pick_inst[6:0] = 7'b0011000;
              end
              6: begin
                pick_inst  = 32'h0F0F0FFF;
                pick_codif = 12'h000;
              end
              default: pick_inst = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) pick_codif = 12'h000;
            if (g == 0) dly = ($urandom_range(0, 24) == 0) ? 1000 : $urandom_range(1, 8);
            else        dly = $urandom_range(1, 6);
            inst_valid = 1'b1;
            inst_in    = pick_inst;
            if (inst_ready) begin
              codif  = pick_codif;
              e.inst = pick_inst;
              if (pick_codif == 12'h000) begin
                e.trap  = 1'b1;
                e.cause = 2'b01;
                e.n     = 0;
                e.unit  = 4;
              end else if (dly <= TO) begin
                e.trap  = 1'b0;
                e.cause = 2'b00;
                e.n     = dly;
                e.unit  = unit_of(pick_inst);
              end else begin
                e.trap  = 1'b1;
                e.cause = 2'b10;
                e.n     = TO;
                e.unit  = unit_of(pick_inst);
              end
              // Accept edge is the next one; decode, dispatch, then n unit cycles.
              e.ev = cyc + 1 + 2 + e.n;
              sb.push_back(e);
              accepted++;
              cur_unit  = e.unit;
              cur_delay = dly;
              exec_cnt  = 0;
            end
          end else begin
            inst_valid = 1'b0;
            inst_in    = $urandom;
          end

          if (accepted >= quota && pops == accepted && traps_seen == traps_acked) break;
        end
        check(g, "all_accepted", (accepted >= quota) ? 32'd1 : 32'd0, 32'd1);
        check(g, "scoreboard_drained", sb.size(), 32'd0);

        if (phase == 0) begin
          // Abort a MUL mid-execution with an asynchronous reset.
          inst_valid = 1'b0;
          w = 0;
          while (!inst_ready && w < 20) begin
            @(negedge clock);
            #1;
            w++;
          end
          inst_valid = 1'b1;
          inst_in    = 32'h02330CB3;
          codif      = 12'h5A5;
          done       = 4'b1101;
          cur_unit   = 4;
          seen = 0;
          w = 0;
          while (seen < 3 && w < 30) begin
            @(negedge clock);
            #1;
            w++;
            inst_valid = 1'b0;
            if (en[1]) seen++;
          end
          check(g, "abort_reached_exec", seen, 32'd3);
          rstn = 1'b0;
          #1;
          check(g, "abort_unit_en", {28'd0, en}, 32'd0);
          check(g, "abort_outputs",
                {25'd0, inst_ready, dec_enable, pc_advance, busy, trap, trap_cause}, 32'd0);
          check(g, "abort_inst_reg", inst_reg, 32'd0);
          traps_acked = traps_seen;
          repeat (2) @(negedge clock);
          check(g, "abort_held_outputs",
                {21'd0, inst_ready, dec_enable, en, pc_advance, busy, trap, trap_cause}, 32'd0);
          rstn     = 1'b1;
          drv_free = cyc + 1;
          exec_cnt = 0;
        end
      end
      inst_valid   = 1'b0;
      lane_done[g] = 1'b1;
    end
  end

  initial begin
    wait (lane_done[0] && lane_done[1]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at time %0t, required completion",
             $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/deco_sequencer.md
# deco_sequencer

- Instruction-issue controller for the core's decode stage.
- Accepts a fetched instruction through a valid/ready handshake and latches it into the decoder's `inst` input.
- Pulses the decoder enable, then dispatches the decoded instruction to one execution unit (ALU, MULT, IRQ, MEM) and waits for that unit's done.
- Retires with a PC-advance pulse, or traps on an illegal encoding or a unit timeout.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum EXEC cycles granted to a unit before a timeout trap. Legal range 1..255.

Ports:
- `clock` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `inst_valid` in 1: fetch presents an instruction.
- `inst_in` in 32: fetched instruction.
- `inst_ready` out 1: sequencer can accept an instruction.
- `inst_reg` out 32: latched instruction; drives the decoder `inst` input.
- `dec_enable` out 1: decoder enable.
- `codif` in 12: decoder output. 12'h000 means invalid instruction.
- `alu_en`, `mul_en`, `irq_en`, `mem_en` out 1 each: unit enables.
- `alu_done`, `mul_done`, `irq_done`, `mem_done` in 1 each: unit completion.
- `pc_advance` out 1: retire pulse.
- `busy` out 1: an instruction is in flight.
- `trap` out 1: trap pending.
- `trap_cause` out 2: 01 = illegal, 10 = timeout.
- `trap_ack` in 1: handler acknowledges the trap.

## Operation
FSM states: IDLE, FETCH, DECODE, DISPATCH, EXEC, RETIRE, TRAP. All outputs are decoded from the state and registers (Moore).

- **IDLE** (reset state): go to FETCH unconditionally on the next edge.
- **FETCH**: `inst_ready`=1.
  - On an edge with `inst_valid`=1: `inst_reg`<=`inst_in`, go to DECODE.
  - `inst_in` is ignored when `inst_valid`=0.
- **DECODE**: `dec_enable`=1 for exactly one cycle, then DISPATCH. The decoder registers `codif` on this edge.
- **DISPATCH**: sample `codif`.
  - If `codif`==0: `trap_cause`<=01, go to TRAP.
  - Otherwise select the unit from `inst_reg`:
    - opcode 0110011 with bit 25 = 1: MULT.
    - opcode 0011000: IRQ.
    - opcode 0000011 or 0100011: MEM.
    - any other opcode: ALU.
  - Register the selection, clear the watchdog, go to EXEC.
- **EXEC**: only the selected unit's `*_en`=1.
  - On the selected done: go to RETIRE.
  - Done inputs of non-selected units are ignored.
  - Watchdog increments each EXEC cycle. If it equals `TIMEOUT`-1 with no done: `trap_cause`<=10, go to TRAP.
  - Done and timeout in the same cycle: done wins.
- **RETIRE**: `pc_advance`=1 for one cycle, then FETCH.
- **TRAP**: `trap`=1, `trap_cause` held stable.
  - On `trap_ack`: clear `trap_cause`, go to FETCH. No `pc_advance` is issued.
  - `trap_ack` outside TRAP is ignored.
- `busy`=1 in DECODE, DISPATCH, EXEC, RETIRE and TRAP.

## Timing
- **Reset values** (while `rstn`=0, asserted asynchronously): state IDLE, `inst_reg`=0, watchdog 0, unit selection cleared, `trap_cause`=00. Every output is 0.
- **After reset release**: `inst_ready` rises one cycle after the first clock edge.
- **Handshake**: transfer occurs on an edge where `inst_valid`&&`inst_ready`. `inst_ready` is 0 from the next cycle until the return to FETCH.
- **Latency from accept edge E** (unit done in its first EXEC cycle):
  - `dec_enable` high in cycle E..E+1.
  - `*_en` high in cycle E+2..E+3.
  - `pc_advance` high in cycle E+3..E+4.
  - `inst_ready` high again from E+4.
  - Best-case throughput: one instruction per 5 cycles.
- **Enable hold**: `*_en` stays high for every EXEC cycle and deasserts on the edge where done is sampled.
- **Timeout**: with no done, the unit is granted exactly `TIMEOUT` EXEC cycles. `trap` rises on the following cycle.
- **Reset mid-operation**: `rstn` low in any state aborts immediately. No `pc_advance` and no trap are produced for the aborted instruction.

## Structure
- **Package `deco_seq_pkg`** holds:
  - state enum;
  - unit-select enum (ALU/MULT/IRQ/MEM);
  - opcode constants `OP_RTYPE`=0110011, `OP_IRQ`=0011000, `OP_LOAD`=0000011, `OP_STORE`=0100011;
  - trap cause codes `TRAP_ILLEGAL`=2'b01, `TRAP_TIMEOUT`=2'b10;
  - `CODIF_INVALID`=12'h000.
- **Sub-module `deco_seq_watchdog`**: 8-bit counter with clear/enable inputs and an `expired` output (count==`TIMEOUT`-1).

## Test plan
- **Reset**: hold `rstn`=0 with `inst_valid`=1 → all outputs 0. Release → `inst_ready`=1 one cycle after the first edge; no instruction is accepted before that.
- **ADDI**: `inst_in`=32'hAA330D93, `codif`≠0, `alu_done` tied 1 → `inst_reg`=32'hAA330D93, `alu_en` for exactly 1 cycle, `pc_advance` at E+3, `inst_ready` at E+4.
- **MUL**: `inst_in`=32'h02330CB3, `mul_done` asserted 6 cycles after `mul_en` rises, `alu_done`=1 throughout → only `mul_en` is high, for 6 cycles; then one `pc_advance`.
- **Illegal**: `inst_in`=32'h0F0F0FFF with `codif`=0 → no unit enable, `trap`=1, `trap_cause`=01 until `trap_ack`; no `pc_advance`.
- **Timeout**: `TIMEOUT`=4, LW 32'hAA332D83, `mem_done` never asserted → `mem_en` high exactly 4 cycles, then `trap_cause`=10. `mem_done` on the 4th EXEC cycle instead → retire, no trap.
- **Reset mid-EXEC**: drop `rstn` during the MUL wait → `mul_en` falls asynchronously, state IDLE, no `pc_advance`; the next instruction is accepted normally.
